// File: rtl/adc_filter_if.sv
// Bundle between the SPI ADC front end and the per-channel averaging filter.
// The front end drives the raw results and strobes; the filter returns the averages and flags.
interface adc_filter_if;
    logic [7:0][9:0] adc;
    logic [7:0]      err;
    logic [7:0]      sample;
    logic [7:0][9:0] avg;
    logic [7:0]      valid;
    logic [7:0]      above;
    logic [7:0]      fault;

    modport master (output adc, err, sample, input avg, valid, above, fault);
    modport slave  (input adc, err, sample, output avg, valid, above, fault);
endinterface

// File: rtl/adc_filter.sv
// Eight independent channels. Each one block-averages the accepted ADC samples,
// tracks a hysteretic threshold flag, and raises a fault after repeated conversion errors.
module adc_filter #(
    parameter int unsigned AVG_LOG2  = 3,
    parameter logic [9:0]  TH_HI     = 10'd600,
    parameter logic [9:0]  TH_LO     = 10'd400,
    parameter logic [3:0]  ERR_LIMIT = 4'd3
) (
    input  logic        clk,
    input  logic        aclr,
    input  logic        sclr,
    adc_filter_if.slave bus
);
    localparam int unsigned NCH    = 8;
    localparam int unsigned DW     = 10;
    localparam int unsigned ACC_W  = DW + AVG_LOG2;
    localparam int unsigned CNT_W  = AVG_LOG2;
    localparam int unsigned ECNT_W = 4;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [ACC_W-1:0]  acc_q, acc_d, sum;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic [ECNT_W-1:0] ecnt_q, ecnt_d, ecnt_inc;
        logic [DW-1:0]     avg_q, avg_d, avg_new;
        logic              valid_q, valid_d;
        logic              above_q, above_d;
        logic              fault_q, fault_d;

        always_comb begin
            acc_d    = acc_q;
            cnt_d    = cnt_q;
            ecnt_d   = ecnt_q;
            avg_d    = avg_q;
            valid_d  = 1'b0;
            above_d  = above_q;
            fault_d  = fault_q;
            sum      = acc_q + ACC_W'(bus.adc[g]);
            avg_new  = DW'(sum >> AVG_LOG2);
            ecnt_inc = (ecnt_q == {ECNT_W{1'b1}}) ? ecnt_q : ecnt_q + ECNT_W'(1);

            if (sclr) begin
                acc_d   = '0;
                cnt_d   = '0;
                ecnt_d  = '0;
                avg_d   = '0;
                above_d = 1'b0;
                fault_d = 1'b0;
            end else if (bus.sample[g] && bus.err[g]) begin
                // Rejected conversions only feed the error streak; the block in progress is untouched.
                ecnt_d = ecnt_inc;
                if (ecnt_inc == ERR_LIMIT) begin
                    fault_d = 1'b1;
                end
            end else if (bus.sample[g]) begin
                ecnt_d  = '0;
                fault_d = 1'b0;
                if (&cnt_q) begin
                    avg_d   = avg_new;
                    acc_d   = '0;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    if (avg_new >= TH_HI) begin
                        above_d = 1'b1;
                    end else if (avg_new < TH_LO) begin
                        above_d = 1'b0;
                    end
                end else begin
                    acc_d = sum;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk or posedge aclr) begin
            if (aclr) begin
                acc_q   <= '0;
                cnt_q   <= '0;
                ecnt_q  <= '0;
                avg_q   <= '0;
                valid_q <= 1'b0;
                above_q <= 1'b0;
                fault_q <= 1'b0;
            end else begin
                acc_q   <= acc_d;
                cnt_q   <= cnt_d;
                ecnt_q  <= ecnt_d;
                avg_q   <= avg_d;
                valid_q <= valid_d;
                above_q <= above_d;
                fault_q <= fault_d;
            end
        end

        assign bus.avg[g]   = avg_q;
        assign bus.valid[g] = valid_q;
        assign bus.above[g] = above_q;
        assign bus.fault[g] = fault_q;
    end

endmodule

// File: tb/tb_adc_filter.sv
// Vector-table bench for adc_filter: each record drives one cycle of strobes and lists the
// flags expected after that edge; completed-block averages go through a scoreboard queue.
module tb_adc_filter;
    logic clk = 1'b0;
    logic aclr;
    logic sclr;
    always #5 clk = ~clk;

    adc_filter_if bus ();

    adc_filter #(
        .AVG_LOG2 (3),
        .TH_HI    (10'd600),
        .TH_LO    (10'd400),
        .ERR_LIMIT(4'd3)
    ) dut (
        .clk (clk),
        .aclr(aclr),
        .sclr(sclr),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] s;
        logic [7:0] e;
        logic [9:0] a;
        logic [7:0] xv;
        logic [9:0] xa;
        logic [7:0] xab;
        logic [7:0] xf;
        bit         sc;
        bit         ac;
        bit         rp;
    } vec_t;

    typedef struct {
        int         ch;
        logic [9:0] avg;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void add(input logic [7:0] s, input logic [7:0] e, input logic [9:0] a,
                                input logic [7:0] xv, input logic [9:0] xa,
                                input logic [7:0] xab, input logic [7:0] xf,
                                input bit sc = 1'b0, input bit ac = 1'b0, input bit rp = 1'b0);
        vec_t v;
        v.s = s; v.e = e; v.a = a; v.xv = xv; v.xa = xa;
        v.xab = xab; v.xf = xf; v.sc = sc; v.ac = ac; v.rp = rp;
        vecs.push_back(v);
    endfunction

    function automatic void idle(input logic [7:0] xab, input logic [7:0] xf);
        add(8'h00, 8'h00, 10'd0, 8'h00, 10'd0, xab, xf);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int ch = 0; ch < 8; ch++)
            check($sformatf("%s avg[%0d]", tag, ch), 32'(bus.avg[ch]), 32'd0);
        check({tag, " valid"}, 32'(bus.valid), 32'd0);
        check({tag, " above"}, 32'(bus.above), 32'd0);
        check({tag, " fault"}, 32'(bus.fault), 32'd0);
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        bus.sample = v.s;
        bus.err    = v.e;
        sclr       = v.sc;
        aclr       = v.ac;
        for (int ch = 0; ch < 8; ch++) begin
            bus.adc[ch] = v.rp ? 10'(ch * 100) : v.a;
            if (v.xv[ch]) begin
                sb_t x;
                x.ch  = ch;
                x.avg = v.rp ? 10'(ch * 100) : v.xa;
                sbq.push_back(x);
            end
        end
        if (v.ac) begin
            #1;
            check_all_zero($sformatf("v%0d async-clear", idx));
        end
        @(posedge clk);
        #1;
        n_vec++;
        for (int ch = 0; ch < 8; ch++) begin
            if (bus.valid[ch]) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL v%0d unexpected valid[%0d]: got avg %0d, want no pulse",
                             idx, ch, bus.avg[ch]);
                end else begin
                    sb_t x;
                    x = sbq.pop_front();
                    check($sformatf("v%0d valid channel", idx), 32'(ch), 32'(x.ch));
                    check($sformatf("v%0d avg[%0d]", idx, ch), 32'(bus.avg[ch]), 32'(x.avg));
                end
            end
        end
        check($sformatf("v%0d valid", idx), 32'(bus.valid), 32'(v.xv));
        check($sformatf("v%0d above", idx), 32'(bus.above), 32'(v.xab));
        check($sformatf("v%0d fault", idx), 32'(bus.fault), 32'(v.xf));
        if (v.sc || v.ac) check_all_zero($sformatf("v%0d clear", idx));
    endtask

    initial begin
        bus.sample = '0;
        bus.err    = '0;
        bus.adc    = '0;
        sclr       = 1'b0;
        aclr       = 1'b1;

        // ch2: one block of 100..107 averages to 103 (truncated)
        for (int k = 0; k < 8; k++)
            add(8'h04, 8'h00, 10'(100 + k), (k == 7) ? 8'h04 : 8'h00, 10'd103, 8'h00, 8'h00);
        idle(8'h00, 8'h00);

        // ch0: full scale sets above, mid band holds it, 399 drops it
        for (int k = 0; k < 8; k++)
            add(8'h01, 8'h00, 10'd1023, (k == 7) ? 8'h01 : 8'h00, 10'd1023,
                (k == 7) ? 8'h01 : 8'h00, 8'h00);
        idle(8'h01, 8'h00);
        for (int k = 0; k < 8; k++)
            add(8'h01, 8'h00, 10'd500, (k == 7) ? 8'h01 : 8'h00, 10'd500, 8'h01, 8'h00);
        idle(8'h01, 8'h00);
        for (int k = 0; k < 8; k++)
            add(8'h01, 8'h00, 10'd399, (k == 7) ? 8'h01 : 8'h00, 10'd399,
                (k == 7) ? 8'h00 : 8'h01, 8'h00);
        idle(8'h00, 8'h00);

        // ch5: error streak raises and holds fault; accepted samples clear it and complete a block
        for (int k = 0; k < 5; k++)
            add(8'h20, 8'h20, 10'd999, 8'h00, 10'd0, 8'h00, (k >= 2) ? 8'h20 : 8'h00);
        for (int k = 0; k < 8; k++)
            add(8'h20, 8'h00, 10'd50, (k == 7) ? 8'h20 : 8'h00, 10'd50, 8'h00, 8'h00);
        idle(8'h00, 8'h00);

        // ch1: a rejected sample in mid block is skipped entirely
        for (int k = 0; k < 9; k++)
            add(8'h02, (k == 4) ? 8'h02 : 8'h00, (k == 4) ? 10'd1000 : 10'd200,
                (k == 8) ? 8'h02 : 8'h00, 10'd200, 8'h00, 8'h00);
        idle(8'h00, 8'h00);

        // ch3 mid-block clear, synchronous then asynchronous; ch6 carries a fault into it
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 8; k++)
                add(8'h08, 8'h00, 10'd700, (k == 7) ? 8'h08 : 8'h00, 10'd700,
                    (k == 7) ? 8'h08 : 8'h00, 8'h00);
            for (int k = 0; k < 5; k++)
                add((k < 3) ? 8'h48 : 8'h08, (k < 3) ? 8'h40 : 8'h00, 10'd300, 8'h00, 10'd0,
                    8'h08, (k >= 2) ? 8'h40 : 8'h00);
            add(8'h08, 8'h00, 10'd300, 8'h00, 10'd0, 8'h00, 8'h00, r == 0, r == 1);
            for (int k = 0; k < 8; k++)
                add(8'h08, 8'h00, 10'd300, (k == 7) ? 8'h08 : 8'h00, 10'd300, 8'h00, 8'h00);
            idle(8'h00, 8'h00);
        end

        // all channels together, adc = ch*100; 600 hits TH_HI exactly, 400 sits on TH_LO
        for (int k = 0; k < 8; k++)
            add(8'hFF, 8'h00, 10'd0, (k == 7) ? 8'hFF : 8'h00, 10'd0,
                (k == 7) ? 8'hC0 : 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(8'hC0, 8'h00);

        #3;
        check_all_zero("reset asserted");
        @(negedge clk);
        aclr = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("after reset");

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        check("scoreboard drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/adc_filter.md
ADC_FILTER -- requirements
Module: adc_filter

Interface
REQ-001 Parameter AVG_LOG2, default 3, log2 of block-average length; legal range 1..6.
REQ-002 Parameter TH_HI, default 10'd600, upper comparator threshold.
REQ-003 Parameter TH_LO, default 10'd400, lower comparator threshold; TH_LO <= TH_HI SHALL hold.
REQ-004 Parameter ERR_LIMIT, default 4'd3, consecutive-error count (1..15) that raises fault.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 aclr  input  1  reset, asynchronous, active-high.
REQ-007 sclr  input  1  synchronous clear, active-high.
REQ-008 adc  input  [7:0][9:0]  raw per-channel conversion results from the SPI ADC front end.
REQ-009 err  input  [7:0]  per-channel conversion error flag, qualified by sample.
REQ-010 sample  input  [7:0]  per-channel one-cycle strobe: adc[ch]/err[ch] are new.
REQ-011 avg  output  [7:0][9:0]  per-channel block-averaged value.
REQ-012 valid  output  [7:0]  per-channel one-cycle pulse: avg[ch] just updated.
REQ-013 above  output  [7:0]  per-channel hysteretic threshold flag.
REQ-014 fault  output  [7:0]  per-channel consecutive-error fault flag.

Function
REQ-015 The block SHALL contain 8 independent, identical channel pipelines; sample pulses on several channels in the same cycle SHALL all be processed that cycle.
REQ-016 Each channel SHALL hold an accumulator of 10+AVG_LOG2 bits, a sample counter of AVG_LOG2 bits, and an error counter of 4 bits.
REQ-017 Accepted sample: sample[ch]=1 and err[ch]=0.
REQ-018 Rejected sample: sample[ch]=1 and err[ch]=1; it SHALL NOT touch the accumulator or sample counter.
REQ-019 Accepted sample with counter < 2^AVG_LOG2-1: acc += adc[ch], counter += 1.
REQ-020 Accepted sample with counter == 2^AVG_LOG2-1: avg[ch] <= (acc + adc[ch]) >> AVG_LOG2 (truncating), acc <= 0, counter <= 0, valid[ch] <= 1.
REQ-021 Latency: avg[ch] and valid[ch] SHALL change on the clock edge that samples the completing strobe (registered, visible one cycle after strobe asserted).
REQ-022 valid[ch] SHALL be high for exactly one cycle per completed block, low otherwise.
REQ-023 Accumulator SHALL never overflow: max sum 2^AVG_LOG2 * 1023 fits its width.
REQ-024 On each valid update: new avg >= TH_HI -> above[ch] <= 1; new avg < TH_LO -> above[ch] <= 0; otherwise hold; above updates on the same edge as avg.
REQ-025 Rejected sample: error counter += 1, saturating at 15; when the incremented value == ERR_LIMIT, fault[ch] <= 1.
REQ-026 Accepted sample: error counter <= 0 and fault[ch] <= 0 on the same edge.
REQ-027 fault[ch] SHALL remain 1 while rejected samples continue beyond ERR_LIMIT.
REQ-028 No strobe: all channel state SHALL hold.

Reset
REQ-029 aclr SHALL immediately clear avg, valid, above, fault, accumulators, sample counters, error counters to 0.
REQ-030 sclr SHALL clear the same state on the next edge, priority over any simultaneous sample strobe.
REQ-031 Reset mid-block SHALL discard the partial sum; the next block starts from counter 0.

Verification
REQ-032 AVG_LOG2=3, ch2: 8 accepted strobes adc=100..107 -> single valid[2] pulse after 8th, avg[2]=103, above[2]=0, other channels' valid=0.
REQ-033 Ch0: 8 strobes adc=1023 -> avg[0]=1023, above[0]=1; then 8 strobes adc=500 -> avg=500, above[0] stays 1; then 8 strobes adc=399 -> above[0]=0.
REQ-034 Ch5: 3 strobes err=1 -> fault[5]=1 after 3rd; 2 more err strobes -> fault stays 1, no valid; 1 accepted strobe -> fault[5]=0, counter state intact.
REQ-035 Ch1: 4 accepted strobes, 1 rejected, 4 accepted (adc=200) -> valid[1] on the 9th strobe only, avg[1]=200.
REQ-036 Ch3: 5 accepted strobes then sclr pulse (aclr pulse in a repeat run) coincident with a strobe -> all outputs 0, next valid only after 8 fresh accepted strobes.
REQ-037 All 8 sample bits high simultaneously for 8 cycles with adc[ch]=ch*100 -> all 8 valid pulses in the same cycle, avg[ch]=ch*100.
